// File: rtl/mdu_if.sv
// E-stage multiply/divide unit handshake: operands and op code in, busy and HI/LO out.
interface mdu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, op, A, B, input busy, HI, LO);
    modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu.sv
// Multi-cycle MIPS multiply/divide unit holding architectural HI/LO; busy stalls MDU ops in D.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (op 7..10) accumulate into HI/LO.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               busy_q, busy_d;

    // Shared 33x33 multiplier: operands are zero- or sign-extended by op.
    logic               mul_signed;
    logic signed [63:0] mul_a;
    logic signed [63:0] mul_b;
    logic [63:0]        prod;

    always_comb begin
        mul_signed = (bus.op == OP_MULT);
`ifdef MDU_MADD_EN
        mul_signed = mul_signed || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
`endif
    end

    assign mul_a = 64'($signed({mul_signed & bus.A[31], bus.A}));
    assign mul_b = 64'($signed({mul_signed & bus.B[31], bus.B}));
    assign prod  = mul_a * mul_b;

`ifdef MDU_MADD_EN
    logic [63:0] acc;
    assign acc = {hi_q, lo_q};
`endif

    // Magnitude divider; signs reapplied after so 0x80000000 / -1 wraps to 0x80000000.
    logic        div_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, dvs;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quo, rem;

    assign div_signed = (bus.op == OP_DIV);
    assign a_neg      = div_signed & bus.A[31];
    assign b_neg      = div_signed & bus.B[31];
    assign a_mag      = a_neg ? (~bus.A + 32'd1) : bus.A;
    assign b_mag      = b_neg ? (~bus.B + 32'd1) : bus.B;
    assign dvs        = (bus.B == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / dvs;
    assign r_mag      = a_mag % dvs;
    assign quo        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

    // Next-state, pending result and HI/LO update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = S_RUN;
                        end
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU: begin
                            {pend_hi_d, pend_lo_d} = acc + prod;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = S_RUN;
                        end
                        OP_MSUB, OP_MSUBU: begin
                            {pend_hi_d, pend_lo_d} = acc - prod;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = S_RUN;
                        end
`endif
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = rem;
                            pend_lo_d = quo;
                            pend_wr_d = (bus.B != 32'd0);
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = S_RUN;
                        end
                        OP_MTHI: hi_d = bus.A;
                        OP_MTLO: lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the forwarded register-file read operands (rs → A, rt → B).
- Holds architectural HI/LO.
- Models multi-cycle latency through a busy flag, which the hazard unit uses to stall MDU instructions in D.
- Results reach the GRF via the mfhi/mflo path (E-stage mux on HI/LO).

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (≥1)
- DIV_CYCLES, 10, busy duration for div/divu (≥1)

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  E-stage MDU instruction valid this cycle
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; others NONE
- A  input  32  operand from rs (forwarded)
- B  input  32  operand from rt (forwarded)
- busy  output  1  operation in progress
- HI  output  32  architectural HI
- LO  output  32  architectural LO

Behaviour:
- Reset, synchronous on rst=1 at posedge:
  - HI=0, LO=0, busy=0, cycle counter=0, state=IDLE.
  - Pending result discarded.
  - rst has priority over start.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; counter counts down from N to 1; pending {hi_n, lo_n} held in internal regs.
- Accept: start=1 and op∈{1..4,7..10} in IDLE at edge T:
  - Operands latched; result computed combinationally and stored in pending regs.
  - counter=N (MULT_CYCLES for mult-class, DIV_CYCLES for div-class).
  - → RUN.
  - busy=1 during cycles T+1 … T+N.
  - At edge T+N: HI/LO ← pending, → IDLE.
  - New HI/LO visible and busy=0 from cycle T+N+1.
  - Back-to-back accept is allowed at edge T+N+1.
- start while busy=1: ignored entirely; HI/LO and the pending op are unaffected. The hazard unit guarantees this never occurs; the bench still checks it.
- MTHI / MTLO (op 5/6) in IDLE:
  - HI←A (resp. LO←A) at that edge, visible next cycle.
  - busy never asserts.
  - Ignored while busy.
- Arithmetic:
  - MULT: {HI,LO} = signed(A)×signed(B), full 64-bit.
  - MULTU: unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend A.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0 (no trap).
  - DIVU: unsigned quotient/remainder.
- Divide by zero (B=0, div or divu): full DIV_CYCLES busy period still runs; HI/LO retain prior values at completion.
- op NONE or unused codes with start=1: no effect.
- Reset in RUN: abort immediately; next cycle busy=0, HI=LO=0.
- HI/LO change only at: reset, MTHI/MTLO edges, or the completion edge.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - MADD/MADDU: {HI,LO} += product, where product is signed (MADD) or unsigned (MADDU) and the accumulator is the {HI,LO} value at accept time.
  - MSUB/MSUBU: {HI,LO} -= product.
  - Accumulation is modulo 2^64.
  - All four use MULT_CYCLES latency and busy timing identical to MULT.
- Undefined: op 7–10 treated as NONE (no busy, no HI/LO change).

Test Plan:
- Reset: rst=1 one edge after arbitrary state → HI=0, LO=0, busy=0 next cycle.
- MULT A=0xFFFFFFFF B=2 at edge T:
  - busy=1 exactly in cycles T+1..T+5, HI/LO unchanged during busy.
  - From T+6: HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - Repeat with MULTU → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2:
  - After 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 → LO=3, HI=1.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU A=7 B=0 with prior HI=0x11, LO=0x22 → busy 10 cycles, then HI=0x11, LO=0x22.
- Busy interference:
  - MTHI A=0x1234 while busy=1 → ignored.
  - MTHI after completion → HI=0x1234 next cycle, busy stays 0.
  - MULT start mid-DIV → ignored; DIV result written.
- Reset mid-op: DIV accepted, rst at 3rd busy cycle → busy=0, HI=LO=0, no later write.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1 B=1 → HI=1, LO=0.
